// File: rtl/key_entry_if.sv
// Keypad/button handshake bundle between the key entry controller and its environment.
// The master side drives keys, ticks and buttons; the slave side returns the entry buffer and strobes.
interface key_entry_if;
   logic       one_second;
   logic       key_valid;
   logic [3:0] key;
   logic       time_button;
   logic       alarm_button;
   logic [3:0] new_time_ms_hr;
   logic [3:0] new_time_ls_hr;
   logic [3:0] new_time_ms_min;
   logic [3:0] new_time_ls_min;
   logic       load_new_c;
   logic       load_new_a;
   logic       show_new_time;
   logic       show_a;
   logic       entry_error;

   modport master (
      output one_second, key_valid, key, time_button, alarm_button,
      input  new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
      input  load_new_c, load_new_a, show_new_time, show_a, entry_error
   );

   modport slave (
      input  one_second, key_valid, key, time_button, alarm_button,
      output new_time_ms_hr, new_time_ls_hr, new_time_ms_min, new_time_ls_min,
      output load_new_c, load_new_a, show_new_time, show_a, entry_error
   );
endinterface

// File: rtl/key_entry_ctrl.sv
// Alarm clock keypad front-end: shifts BCD digits into an HH:MM buffer, validates it,
// and commits it to the time counter or alarm register on a button edge.
module key_entry_ctrl #(
   parameter int TIMEOUT_SEC = 10
) (
   input logic        clk,
   input logic        reset,
   key_entry_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ENTRY, SHOW_ALARM} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_SEC);

   state_t     state_q, state_d;
   logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
   logic [3:0] ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
   logic [7:0] cnt_q, cnt_d;
   logic       time_prev, alarm_prev;
   logic       load_c_q, load_c_d;
   logic       load_a_q, load_a_d;
   logic       err_q, err_d;
   logic       show_new_q, show_a_q;

   logic rise_t, rise_a, is_digit, is_clear, buf_valid;

   assign rise_t    = bus.time_button & ~time_prev;
   assign rise_a    = bus.alarm_button & ~alarm_prev;
   assign is_digit  = bus.key_valid && (bus.key <= 4'd9);
   assign is_clear  = bus.key_valid && (bus.key == 4'd10);
   // Hours 00-23 and minutes 00-59; ls_min is always a digit but is checked anyway.
   assign buf_valid = (ms_hr_q <= 4'd2) && (ms_min_q <= 4'd5) && (ls_min_q <= 4'd9) &&
                      ((ms_hr_q == 4'd2) ? (ls_hr_q <= 4'd3) : (ls_hr_q <= 4'd9));

   // Next-state and next-output logic; a button edge in ENTRY swallows any key or tick that cycle.
   always_comb begin
      state_d  = state_q;
      ms_hr_d  = ms_hr_q;
      ls_hr_d  = ls_hr_q;
      ms_min_d = ms_min_q;
      ls_min_d = ls_min_q;
      cnt_d    = cnt_q;
      load_c_d = 1'b0;
      load_a_d = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_digit) begin
               ms_hr_d  = 4'd0;
               ls_hr_d  = 4'd0;
               ms_min_d = 4'd0;
               ls_min_d = bus.key;
               cnt_d    = 8'd0;
               state_d  = ENTRY;
            end else if (bus.alarm_button) begin
               state_d = SHOW_ALARM;
            end
         end
         SHOW_ALARM: begin
            if (!bus.alarm_button) state_d = IDLE;
         end
         ENTRY: begin
            if (rise_t || rise_a) begin
               if (buf_valid) begin
                  load_c_d = rise_t;
                  load_a_d = ~rise_t;
                  state_d  = IDLE;
               end else begin
                  err_d = 1'b1;
               end
            end else if (is_digit) begin
               ms_hr_d  = ls_hr_q;
               ls_hr_d  = ms_min_q;
               ms_min_d = ls_min_q;
               ls_min_d = bus.key;
               cnt_d    = 8'd0;
            end else if (is_clear) begin
               ms_hr_d  = 4'd0;
               ls_hr_d  = 4'd0;
               ms_min_d = 4'd0;
               ls_min_d = 4'd0;
               cnt_d    = 8'd0;
            end else if (bus.one_second) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == TIMEOUT_CNT) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and every output are registered so downstream sees glitch-free strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ms_hr_q    <= 4'd0;
         ls_hr_q    <= 4'd0;
         ms_min_q   <= 4'd0;
         ls_min_q   <= 4'd0;
         cnt_q      <= 8'd0;
         time_prev  <= 1'b0;
         alarm_prev <= 1'b0;
         load_c_q   <= 1'b0;
         load_a_q   <= 1'b0;
         err_q      <= 1'b0;
         show_new_q <= 1'b0;
         show_a_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ms_hr_q    <= ms_hr_d;
         ls_hr_q    <= ls_hr_d;
         ms_min_q   <= ms_min_d;
         ls_min_q   <= ls_min_d;
         cnt_q      <= cnt_d;
         time_prev  <= bus.time_button;
         alarm_prev <= bus.alarm_button;
         load_c_q   <= load_c_d;
         load_a_q   <= load_a_d;
         err_q      <= err_d;
         show_new_q <= (state_d == ENTRY);
         show_a_q   <= (state_d == SHOW_ALARM);
      end
   end

   assign bus.new_time_ms_hr  = ms_hr_q;
   assign bus.new_time_ls_hr  = ls_hr_q;
   assign bus.new_time_ms_min = ms_min_q;
   assign bus.new_time_ls_min = ls_min_q;
   assign bus.load_new_c      = load_c_q;
   assign bus.load_new_a      = load_a_q;
   assign bus.show_new_time   = show_new_q;
   assign bus.show_a          = show_a_q;
   assign bus.entry_error     = err_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: a decimal-value reference model checked every cycle,
// plus directed scenarios pinned with hand-computed literals.
module tb_key_entry_ctrl;

   localparam int TO = 3;

   logic clk;
   logic reset;
   key_entry_if bus();

   key_entry_ctrl #(.TIMEOUT_SEC(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total_cnt = 0;
   int bad_cnt   = 0;

   // Reference model: buffer held as a 4-digit decimal number HHMM.
   int m_val;
   int m_cnt;
   bit m_entry, m_show, m_lc, m_la, m_err, m_tp, m_ap;
   bit started = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic model_reset();
      m_val = 0; m_cnt = 0;
      m_entry = 0; m_show = 0; m_lc = 0; m_la = 0; m_err = 0; m_tp = 0; m_ap = 0;
      started = 1'b1;
   endtask

   task automatic model_step();
      bit rt, ra, dig, clr, ok;
      rt  = bus.time_button && !m_tp;
      ra  = bus.alarm_button && !m_ap;
      dig = bus.key_valid && (int'(bus.key) < 10);
      clr = bus.key_valid && (int'(bus.key) == 10);
      ok  = ((m_val / 100) <= 23) && ((m_val % 100) <= 59);
      m_lc = 0; m_la = 0; m_err = 0;
      if (m_show) begin
         if (!bus.alarm_button) m_show = 0;
      end else if (!m_entry) begin
         if (dig) begin
            m_val = int'(bus.key); m_entry = 1; m_cnt = 0;
         end else if (bus.alarm_button) begin
            m_show = 1;
         end
      end else if (rt || ra) begin
         if (ok) begin
            if (rt) m_lc = 1; else m_la = 1;
            m_entry = 0;
         end else begin
            m_err = 1;
         end
      end else if (dig) begin
         m_val = (m_val * 10 + int'(bus.key)) % 10000; m_cnt = 0;
      end else if (clr) begin
         m_val = 0; m_cnt = 0;
      end else if (bus.one_second) begin
         m_cnt++;
         if (m_cnt == TO) m_entry = 0;
      end
      m_tp = bus.time_button;
      m_ap = bus.alarm_button;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) model_reset();
         else model_step();
      end
   end

   function automatic logic [20:0] dut_vec();
      return {bus.new_time_ms_hr, bus.new_time_ls_hr, bus.new_time_ms_min, bus.new_time_ls_min,
              bus.load_new_c, bus.load_new_a, bus.show_new_time, bus.show_a, bus.entry_error};
   endfunction

   function automatic logic [20:0] model_vec();
      logic [15:0] d;
      d = {4'((m_val / 1000) % 10), 4'((m_val / 100) % 10), 4'((m_val / 10) % 10), 4'(m_val % 10)};
      return {d, m_lc, m_la, m_entry, m_show, m_err};
   endfunction

   // Every-cycle comparison of the DUT against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            total_cnt++;
            if (dut_vec() !== model_vec()) begin
               bad_cnt++;
               $display("[TB] FAIL cycle_cmp t=%0t dut=%h model=%h", $time, dut_vec(), model_vec());
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] dig, input logic [4:0] fl);
      logic [20:0] exp;
      exp = {dig, fl};
      total_cnt++;
      if (dut_vec() !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s dut=%h expected=%h", name, dut_vec(), exp);
      end
      total_cnt++;
      if (model_vec() !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s_model model=%h expected=%h", name, model_vec(), exp);
      end
   endtask

   // One clock of stimulus; strobes drop right after the edge, button levels are re-driven each call.
   task automatic applyStimulus(input bit kv, input logic [3:0] k, input bit tb, input bit ab, input bit os);
      bus.key_valid    = kv;
      bus.key          = k;
      bus.time_button  = tb;
      bus.alarm_button = ab;
      bus.one_second   = os;
      @(posedge clk);
      #1;
      bus.key_valid  = 1'b0;
      bus.one_second = 1'b0;
   endtask

   task automatic press(input logic [3:0] k);
      applyStimulus(1'b1, k, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset = 1'b1;
      bus.key_valid = 1'b0; bus.key = 4'd0; bus.time_button = 1'b0;
      bus.alarm_button = 1'b0; bus.one_second = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checkOutput("reset_state", 16'h0000, 5'b00000);

      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      checkOutput("entry_buffer", 16'h1234, 5'b00100);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("load_c_pulse", 16'h1234, 5'b10000);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("load_c_done", 16'h1234, 5'b00000);

      press(4'd2); press(4'd3); press(4'd5); press(4'd9);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("load_a_pulse", 16'h2359, 5'b01000);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("show_alarm", 16'h2359, 5'b00010);
      applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
      checkOutput("show_alarm_key", 16'h2359, 5'b00010);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("alarm_release", 16'h2359, 5'b00000);

      press(4'd2); press(4'd4); press(4'd0); press(4'd0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("entry_error", 16'h2400, 5'b00101);
      applyStimulus(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
      checkOutput("clear_key", 16'h0000, 5'b00100);
      for (int i = 0; i < 4; i++) press(4'd0);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("load_c_zero", 16'h0000, 5'b10000);

      for (int i = 1; i <= 5; i++) press(4'(i));
      checkOutput("drop_oldest", 16'h2345, 5'b00100);
      press(4'd12);
      checkOutput("ignored_key", 16'h2345, 5'b00100);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

      press(4'd7);
      tick(); tick();
      checkOutput("timeout_pending", 16'h0007, 5'b00100);
      tick();
      checkOutput("timeout_idle", 16'h0007, 5'b00000);

      press(4'd7);
      tick(); tick();
      press(4'd8);
      tick(); tick();
      checkOutput("timeout_restart", 16'h0078, 5'b00100);
      tick();
      checkOutput("timeout_after_restart", 16'h0078, 5'b00000);

      press(4'd0); press(4'd9); press(4'd3); press(4'd0);
      applyStimulus(1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
      checkOutput("simul_commit", 16'h0930, 5'b10000);
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      checkOutput("alarm_edge_consumed", 16'h0930, 5'b00010);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      bus.time_button = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_mid_entry", 16'h0000, 5'b00000);
      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      checkOutput("post_reset", 16'h0000, 5'b00000);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
